calc_cmd_sequencer: RTL and testbench

Sits between the keypad decoder and the calculator core. Buffers keypad commands in a small FIFO and issues them to the core one at a time. After each command it waits for the core's status handshake (ready 2'b10, busy 2'b01, error 2'b00) to complete before issuing the next, and drives an idle NOP code in between. It also detects core error and hung-busy conditions.

---
 rtl/calc_pkg.sv | 29 ++
 rtl/calc_cmd_fifo.sv | 64 ++++++
 rtl/calc_cmd_sequencer.sv | 143 ++++++++++++++
 tb/tb_calc_cmd_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared status codes, command codes and sequencer state encoding for the
// keypad-to-core command path.
package calc_pkg;

    localparam logic [1:0] ST_ERROR = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    localparam logic [3:0] CMD_ADD  = 4'd10;
    localparam logic [3:0] CMD_SUB  = 4'd11;
    localparam logic [3:0] CMD_MUL  = 4'd12;
    localparam logic [3:0] CMD_NOP  = 4'd13;
    localparam logic [3:0] CMD_EQ   = 4'd14;
    localparam logic [3:0] CMD_BKSP = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_READY,
        FAULT
    } seq_state_e;

    // 2'b11 is not a legal core status and is handled like an error.
    function automatic logic is_fault_status(input logic [1:0] status);
        return (status == ST_ERROR) || (status == 2'b11);
    endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// DEPTH x 4-bit synchronous FIFO for queued keypad commands, with a
// single-cycle flush that empties it regardless of push/pop.
module calc_cmd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [3:0]               din,
    output logic [3:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A pop frees the slot this push needs, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Queues keypad commands and issues them to the calculator core one at a
// time, pacing on the core's ready/busy handshake and trapping core errors.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | NOP on calc_cmd; pop head when queue non-empty and core ready
// ISSUE      | popped command held on calc_cmd for HOLD_CYCLES cycles
// WAIT_BUSY  | waiting up to BUSY_WINDOW cycles for core to report busy
// WAIT_READY | core busy; waiting for ready, TIMEOUT cycles at most
// FAULT      | core reported error; queue flushed, input blocked until reset
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int         DEPTH       = 8,
    parameter int         HOLD_CYCLES = 2,
    parameter int         BUSY_WINDOW = 4,
    parameter int         TIMEOUT     = 64,
    parameter logic [3:0] NOP_CMD     = CMD_NOP
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     key_valid,
    input  logic [3:0]               key_cmd,
    output logic                     key_ready,
    input  logic [1:0]               calc_status,
    output logic [3:0]               calc_cmd,
    output logic                     seq_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     timeout_pulse,
    output logic                     calc_error
);

    localparam int WW = $clog2(BUSY_WINDOW + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0]    HOLD_LAST = 3'(HOLD_CYCLES);
    localparam logic [WW-1:0] WIN_LAST  = WW'(BUSY_WINDOW - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    seq_state_e    state;
    logic [2:0]    hold_cnt;
    logic [WW-1:0] win_cnt;
    logic [TW-1:0] to_cnt;

    logic       fault_in;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_flush;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_head;

    assign fault_in   = is_fault_status(calc_status);
    assign fifo_flush = fault_in || (state == FAULT);
    assign key_ready  = !reset && !fifo_full && (state != FAULT);
    // NOP keys complete the handshake but never occupy a slot.
    assign fifo_push  = key_valid && key_ready && (key_cmd != NOP_CMD);
    assign fifo_pop   = (state == IDLE) && !fifo_empty && (calc_status == ST_READY);
    assign seq_busy   = (state != IDLE) || !fifo_empty;

    calc_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (key_cmd),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            calc_cmd      <= NOP_CMD;
            timeout_pulse <= 1'b0;
            calc_error    <= 1'b0;
            hold_cnt      <= '0;
            win_cnt       <= '0;
            to_cnt        <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            if (fault_in) begin
                state      <= FAULT;
                calc_error <= 1'b1;
                calc_cmd   <= NOP_CMD;
            end else begin
                case (state)
                    IDLE: begin
                        calc_cmd <= NOP_CMD;
                        if (fifo_pop) begin
                            state    <= ISSUE;
                            calc_cmd <= fifo_head;
                            hold_cnt <= 3'd1;
                        end
                    end
                    ISSUE: begin
                        if (hold_cnt >= HOLD_LAST) begin
                            state    <= WAIT_BUSY;
                            calc_cmd <= NOP_CMD;
                            win_cnt  <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 3'd1;
                        end
                    end
                    WAIT_BUSY: begin
                        if (calc_status == ST_BUSY) begin
                            state  <= WAIT_READY;
                            to_cnt <= '0;
                        end else if (win_cnt >= WIN_LAST) begin
                            state <= IDLE;
                        end else begin
                            win_cnt <= win_cnt + WW'(1);
                        end
                    end
                    WAIT_READY: begin
                        if (calc_status == ST_READY) begin
                            state <= IDLE;
                        end else if (to_cnt >= TO_LAST) begin
                            // Hung core: drop the command rather than retry it.
                            timeout_pulse <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            to_cnt <= to_cnt + TW'(1);
                        end
                    end
                    FAULT: begin
                        calc_cmd <= NOP_CMD;
                    end
                    default: begin
                        state    <= IDLE;
                        calc_cmd <= NOP_CMD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench for calc_cmd_sequencer with default parameters.
module tb_calc_cmd_sequencer;
    import calc_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_cmd = 4'd0;
    logic [1:0] calc_status = ST_READY;
    logic       key_ready;
    logic [3:0] calc_cmd;
    logic       seq_busy;
    logic [3:0] fifo_count;
    logic       timeout_pulse;
    logic       calc_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    calc_cmd_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_cmd       (key_cmd),
        .key_ready     (key_ready),
        .calc_status   (calc_status),
        .calc_cmd      (calc_cmd),
        .seq_busy      (seq_busy),
        .fifo_count    (fifo_count),
        .timeout_pulse (timeout_pulse),
        .calc_error    (calc_error)
    );

    task automatic test_reset();
        calc_status = ST_READY;
        #1 reset = 1'b1;
        #1;
        n_checks++; if (calc_cmd !== 4'd13) begin n_fail++; $display("FAIL rst_calc_cmd: got %0d want 13", calc_cmd); end
        n_checks++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL rst_key_ready: got %b want 0", key_ready); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rst_fifo_count: got %0d want 0", fifo_count); end
        n_checks++; if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL rst_seq_busy: got %b want 0", seq_busy); end
        n_checks++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b want 0", timeout_pulse); end
        n_checks++; if (calc_error !== 1'b0) begin n_fail++; $display("FAIL rst_calc_error: got %b want 0", calc_error); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_key_ready: got %b want 1", key_ready); end
        @(negedge clock);
    endtask

    task automatic test_single();
        calc_status = ST_READY;
        key_valid = 1'b1; key_cmd = 4'd5;
        @(negedge clock);
        key_valid = 1'b0;
        n_checks++; if (calc_cmd !== 4'd13) begin n_fail++; $display("FAIL single_pushcycle_cmd: got %0d want 13", calc_cmd); end
        n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL single_pushcycle_count: got %0d want 1", fifo_count); end
        @(negedge clock);
        n_checks++; if (calc_cmd !== 4'd5) begin n_fail++; $display("FAIL single_hold1: got %0d want 5", calc_cmd); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL single_popped_count: got %0d want 0", fifo_count); end
        n_checks++; if (seq_busy !== 1'b1) begin n_fail++; $display("FAIL single_seq_busy: got %b want 1", seq_busy); end
        @(negedge clock);
        n_checks++; if (calc_cmd !== 4'd5) begin n_fail++; $display("FAIL single_hold2: got %0d want 5", calc_cmd); end
        @(negedge clock);
        n_checks++; if (calc_cmd !== 4'd13) begin n_fail++; $display("FAIL single_after_hold: got %0d want 13", calc_cmd); end
        calc_status = ST_BUSY;
        key_valid = 1'b1; key_cmd = 4'd7;
        @(negedge clock);
        key_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            n_checks++; if (calc_cmd !== 4'd13 || fifo_count !== 4'd1) begin n_fail++; $display("FAIL single_busy_hold[%0d]: cmd %0d count %0d want 13/1", i, calc_cmd, fifo_count); end
        end
        calc_status = ST_READY;
        @(negedge clock);
        n_checks++; if (calc_cmd !== 4'd13 || fifo_count !== 4'd1) begin n_fail++; $display("FAIL single_ready_seen: cmd %0d count %0d want 13/1", calc_cmd, fifo_count); end
        @(negedge clock);
        n_checks++; if (calc_cmd !== 4'd7 || fifo_count !== 4'd0) begin n_fail++; $display("FAIL single_next_issue: cmd %0d count %0d want 7/0", calc_cmd, fifo_count); end
        repeat (10) @(negedge clock);
        n_checks++; if (seq_busy !== 1'b0 || calc_cmd !== 4'd13) begin n_fail++; $display("FAIL single_drain: busy %b cmd %0d want 0/13", seq_busy, calc_cmd); end
    endtask

    task automatic test_burst();
        int         got[$];
        int         runlen[$];
        logic [3:0] prev;
        int         to_seen;
        calc_status = ST_BUSY;
        for (int i = 1; i <= 9; i++) begin
            key_cmd = 4'(i); key_valid = 1'b1;
            n_checks++; if (key_ready !== 1'(i <= 8)) begin n_fail++; $display("FAIL burst_key_ready[%0d]: got %b want %b", i, key_ready, (i <= 8)); end
            @(negedge clock);
        end
        key_valid = 1'b0;
        n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL burst_full_count: got %0d want 8", fifo_count); end
        n_checks++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL burst_full_ready: got %b want 0", key_ready); end
        calc_status = ST_READY;
        prev = 4'd13;
        to_seen = 0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clock);
            if (timeout_pulse) to_seen++;
            if (calc_cmd != 4'd13) begin
                if (prev == 4'd13) begin got.push_back(int'(calc_cmd)); runlen.push_back(0); end
                runlen[runlen.size()-1] = runlen[runlen.size()-1] + 1;
            end
            prev = calc_cmd;
        end
        n_checks++; if (got.size() != 8) begin n_fail++; $display("FAIL burst_issued_count: got %0d want 8", got.size()); end
        for (int k = 0; k < got.size() && k < 8; k++) begin
            n_checks++; if (got[k] != k + 1 || runlen[k] != 2) begin n_fail++; $display("FAIL burst_order[%0d]: cmd %0d len %0d want %0d/2", k, got[k], runlen[k], k + 1); end
        end
        n_checks++; if (to_seen != 0) begin n_fail++; $display("FAIL burst_timeout: got %0d pulses want 0", to_seen); end
        n_checks++; if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL burst_drain_busy: got %b want 0", seq_busy); end
    endtask

    task automatic test_no_busy();
        int t_add = -1;
        int t_sub = -1;
        int to_seen = 0;
        calc_status = ST_READY;
        key_valid = 1'b1; key_cmd = CMD_ADD;
        @(negedge clock);
        key_cmd = CMD_SUB;
        @(negedge clock);
        key_valid = 1'b0;
        for (int t = 0; t < 30; t++) begin
            if (calc_cmd == CMD_ADD && t_add < 0) t_add = t;
            if (calc_cmd == CMD_SUB && t_sub < 0) t_sub = t;
            if (timeout_pulse) to_seen++;
            @(negedge clock);
        end
        n_checks++; if (t_add != 0) begin n_fail++; $display("FAIL nobusy_first_latency: got %0d want 0", t_add); end
        n_checks++; if (t_sub - t_add != 7) begin n_fail++; $display("FAIL nobusy_spacing: got %0d want 7", t_sub - t_add); end
        n_checks++; if (to_seen != 0) begin n_fail++; $display("FAIL nobusy_timeout: got %0d want 0", to_seen); end
    endtask

    task automatic test_hung();
        int w;
        int pulses = 0;
        int at = -1;
        logic [3:0] first = 4'd13;
        calc_status = ST_READY;
        key_valid = 1'b1; key_cmd = 4'd3;
        @(negedge clock);
        key_cmd = 4'd4;
        @(negedge clock);
        key_valid = 1'b0;
        for (w = 0; w < 10 && calc_cmd != 4'd3; w++) @(negedge clock);
        n_checks++; if (calc_cmd !== 4'd3) begin n_fail++; $display("FAIL hung_issue_wait: got %0d want 3", calc_cmd); end
        calc_status = ST_BUSY;
        for (int j = 1; j <= 80; j++) begin
            @(negedge clock);
            if (timeout_pulse) begin pulses++; at = j; end
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL hung_pulse_count: got %0d want 1", pulses); end
        n_checks++; if (at != 67) begin n_fail++; $display("FAIL hung_pulse_time: got %0d want 67", at); end
        n_checks++; if (fifo_count !== 4'd1 || calc_cmd !== 4'd13 || seq_busy !== 1'b1) begin n_fail++; $display("FAIL hung_after: count %0d cmd %0d busy %b want 1/13/1", fifo_count, calc_cmd, seq_busy); end
        calc_status = ST_READY;
        for (w = 0; w < 5 && first == 4'd13; w++) begin
            @(negedge clock);
            first = calc_cmd;
        end
        n_checks++; if (first !== 4'd4) begin n_fail++; $display("FAIL hung_no_retry: got %0d want 4", first); end
        repeat (10) @(negedge clock);
    endtask

    task automatic test_error();
        calc_status = ST_READY;
        for (int i = 1; i <= 4; i++) begin
            key_valid = 1'b1; key_cmd = 4'(i);
            @(negedge clock);
        end
        key_valid = 1'b0;
        calc_status = ST_BUSY;
        @(negedge clock);
        n_checks++; if (fifo_count !== 4'd3) begin n_fail++; $display("FAIL err_queued: got %0d want 3", fifo_count); end
        calc_status = ST_ERROR;
        @(negedge clock);
        n_checks++; if (calc_error !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", calc_error); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL err_flush: got %0d want 0", fifo_count); end
        n_checks++; if (key_ready !== 1'b0 || calc_cmd !== 4'd13) begin n_fail++; $display("FAIL err_outputs: ready %b cmd %0d want 0/13", key_ready, calc_cmd); end
        calc_status = ST_READY;
        key_valid = 1'b1; key_cmd = 4'd2;
        repeat (5) @(negedge clock);
        key_valid = 1'b0;
        n_checks++; if (calc_error !== 1'b1 || fifo_count !== 4'd0 || key_ready !== 1'b0 || calc_cmd !== 4'd13) begin n_fail++; $display("FAIL err_sticky: err %b count %0d ready %b cmd %0d want 1/0/0/13", calc_error, fifo_count, key_ready, calc_cmd); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (calc_error !== 1'b0 || fifo_count !== 4'd0 || seq_busy !== 1'b0 || calc_cmd !== 4'd13 || timeout_pulse !== 1'b0 || key_ready !== 1'b0) begin n_fail++; $display("FAIL err_reset: err %b count %0d busy %b cmd %0d ready %b", calc_error, fifo_count, seq_busy, calc_cmd, key_ready); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL err_release_ready: got %b want 1", key_ready); end
        @(negedge clock);
    endtask

    task automatic test_async_reset();
        int reissued = 0;
        calc_status = ST_READY;
        key_valid = 1'b1; key_cmd = 4'd6;
        @(negedge clock);
        key_valid = 1'b0;
        @(negedge clock);
        n_checks++; if (calc_cmd !== 4'd6) begin n_fail++; $display("FAIL arst_issue: got %0d want 6", calc_cmd); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (calc_cmd !== 4'd13 || seq_busy !== 1'b0 || fifo_count !== 4'd0) begin n_fail++; $display("FAIL arst_immediate: cmd %0d busy %b count %0d want 13/0/0", calc_cmd, seq_busy, fifo_count); end
        @(negedge clock);
        reset = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            if (calc_cmd == 4'd6) reissued++;
        end
        n_checks++; if (reissued != 0) begin n_fail++; $display("FAIL arst_abandon: saw cmd 6 for %0d cycles want 0", reissued); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_no_busy();
        test_hung();
        test_error();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
